adc_spi_master: RTL and testbench

Synchronous SPI master that reads 16-bit frames from an external serial ADC and delivers each 10-bit sample to the filter chain. It is the initiator end of the same mode-0, MSB-first, 16-bit framing our SPI slave receives. It lets the FPGA sample the photosensor front end directly: `voltage` feeds `filter` in place of the slave's output, and `sample_valid` replaces the slave's frame counter as the sample strobe.

---
 rtl/adc_spi_master.sv | 178 +++++++++++++++++
 tb/tb_adc_spi_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_master.sv
// SPI master for a 16-bit serial ADC: mode 0, MSB first, one frame per start request.
// Define AUTO_TRIGGER_EN to replace `start` with a free-running SAMPLE_PERIOD trigger.
module adc_spi_master #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 25000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] txData,
    output logic        sck,
    output logic        sdo,
    input  logic        sdi,
    output logic        cs,
    output logic        busy,
    output logic        done,
    output logic [15:0] rxData,
    output logic [9:0]  voltage,
    output logic        sample_valid,
    output logic        overrun
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int             DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 2 || SAMPLE_PERIOD < 2) begin : g_bad_param
            $error("adc_spi_master: CLK_DIV and SAMPLE_PERIOD must be at least 2");
        end
    endgenerate

    logic [2:0]    state;
    logic [DW-1:0] div;
    logic [4:0]    half;
    logic [14:0]   tx_sr;
    logic [15:0]   rx_sr;
    logic          div_end;
    logic          go;

    assign div_end      = (div == DIV_LAST);
    assign sample_valid = done;

`ifdef AUTO_TRIGGER_EN
    localparam int            TW       = $clog2(SAMPLE_PERIOD);
    localparam logic [TW-1:0] TMR_LAST = TW'(SAMPLE_PERIOD - 1);

    logic [TW-1:0] timer;
    logic          trig;
    logic          pending;
    logic          overrun_r;

    assign trig    = (timer == TMR_LAST);
    assign go      = trig || pending;
    assign overrun = overrun_r;

    always_ff @(posedge clk) begin
        if (!reset) begin
            timer <= '0;
        end else begin
            timer <= trig ? '0 : timer + 1'b1;
        end
    end

    // In IDLE a pending request is served; a trigger landing in the same cycle stays pending.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending   <= 1'b0;
            overrun_r <= 1'b0;
        end else if (state == IDLE) begin
            pending <= pending && trig;
        end else if (trig) begin
            if (pending) begin
                overrun_r <= 1'b1;
            end
            pending <= 1'b1;
        end
    end
`else
    assign go      = start;
    assign overrun = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            div     <= '0;
            half    <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            sck     <= 1'b0;
            sdo     <= 1'b0;
            cs      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rxData  <= '0;
            voltage <= '0;
        end else begin
            case (state)
                IDLE: begin
                    div  <= '0;
                    half <= '0;
                    if (go) begin
                        tx_sr <= txData[14:0];
                        sdo   <= txData[15];
                        cs    <= 1'b0;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end

                // Leaving SETUP is the first rising edge, so bit 15 is sampled CLK_DIV after cs falls.
                SETUP: begin
                    if (div_end) begin
                        div   <= '0;
                        sck   <= 1'b1;
                        rx_sr <= {rx_sr[14:0], sdi};
                        state <= SHIFT;
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                // Half-period k has sck high for even k; the 16th fall ends half 30, half 31 is low.
                SHIFT: begin
                    if (div_end) begin
                        div <= '0;
                        if (half == 5'd31) begin
                            sck   <= 1'b0;
                            cs    <= 1'b1;
                            state <= HOLD;
                        end else begin
                            half <= half + 1'b1;
                            if (sck) begin
                                sck   <= 1'b0;
                                sdo   <= tx_sr[14];
                                tx_sr <= {tx_sr[13:0], 1'b0};
                            end else begin
                                sck   <= 1'b1;
                                rx_sr <= {rx_sr[14:0], sdi};
                            end
                        end
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                HOLD: begin
                    if (div_end) begin
                        div     <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        rxData  <= rx_sr;
                        voltage <= rx_sr[9:0];
                        state   <= DONE;
                    end else begin
                        div <= div + 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_master.sv
// Self-checking bench for adc_spi_master with a behavioural mode-0 ADC slave and a scoreboard queue.
// Build with AUTO_TRIGGER_EN defined to exercise the timer-triggered variant instead of start.
module tb_adc_spi_master;

`ifdef AUTO_TRIGGER_EN
    localparam int CDIV = 2;
    localparam int SPER = 200;
`else
    localparam int CDIV = 4;
    localparam int SPER = 25000;
`endif
    localparam int FRAME = 34 * CDIV;

    typedef struct {
        logic [15:0] rx;
        logic [15:0] tx;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] txData = '0;
    logic        sck, sdo, sdi, cs, busy, done, sample_valid, overrun;
    logic [15:0] rxData;
    logic [9:0]  voltage;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sbq[$];

    logic [15:0] adc_word = '0;
    logic [15:0] adc_sr = '0;
    logic [15:0] mosi_cap = '0;
    int          rise_cnt = 0;

    adc_spi_master #(.CLK_DIV(CDIV), .SAMPLE_PERIOD(SPER)) dut (
        .clk(clk), .reset(reset), .start(start), .txData(txData),
        .sck(sck), .sdo(sdo), .sdi(sdi), .cs(cs), .busy(busy), .done(done),
        .rxData(rxData), .voltage(voltage), .sample_valid(sample_valid), .overrun(overrun)
    );

`ifdef AUTO_TRIGGER_EN
    // Second instance with a trigger period shorter than one frame.
    logic        zero = 1'b0;
    logic        o_sck, o_sdo, o_cs, o_busy, o_done, o_sv, o_overrun;
    logic [15:0] o_rx;
    logic [9:0]  o_volt;

    adc_spi_master #(.CLK_DIV(2), .SAMPLE_PERIOD(50)) dut_ovr (
        .clk(clk), .reset(reset), .start(zero), .txData(txData),
        .sck(o_sck), .sdo(o_sdo), .sdi(zero), .cs(o_cs), .busy(o_busy), .done(o_done),
        .rxData(o_rx), .voltage(o_volt), .sample_valid(o_sv), .overrun(o_overrun)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC slave: MSB out at cs fall, next bit after each falling sck; also captures sdo on rising sck.
    assign sdi = adc_sr[15];
    always @(negedge cs) begin
        adc_sr   = adc_word;
        mosi_cap = '0;
        rise_cnt = 0;
    end
    always @(negedge sck) if (cs === 1'b0) adc_sr = {adc_sr[14:0], 1'b0};
    always @(posedge sck) if (cs === 1'b0) begin
        mosi_cap = {mosi_cap[14:0], sdo};
        rise_cnt++;
    end

    task automatic wait_done(input int budget, output bit got, output int cs_hi);
        got   = 1'b0;
        cs_hi = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (cs) cs_hi++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        start  = 1'b1;
        txData = 16'hFFFF;
        repeat (3) @(negedge clk);
        vectors++;
        if ({sck, cs, sdo, busy, done, sample_valid, overrun} !== 7'b0100000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected %b",
                     {sck, cs, sdo, busy, done, sample_valid, overrun}, 7'b0100000);
        end
        vectors++;
        if ({rxData, voltage} !== 26'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected %h", {rxData, voltage}, 26'h0);
        end
`ifdef AUTO_TRIGGER_EN
        vectors++;
        if (o_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_overrun2: got %b expected 0", o_overrun);
        end
`endif
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cs, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_release: got %b expected %b", {cs, busy}, 2'b10);
        end
    endtask

`ifndef AUTO_TRIGGER_EN
    task automatic test_single_frame;
        bit   got;
        int   cshi, acc, lat;
        exp_t e;
        @(negedge clk);
        adc_word = 16'h02A5;
        txData   = 16'hD000;
        start    = 1'b1;
        sbq.push_back('{rx: 16'h02A5, tx: 16'hD000});
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
        vectors++;
        if ({cs, busy, sdo} !== 3'b011) begin
            miscompares++;
            $display("FAIL accept: got %b expected %b", {cs, busy, sdo}, 3'b011);
        end
        wait_done(400, got, cshi);
        e   = sbq.pop_front();
        lat = cyc - acc + 1;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("FAIL single_timeout: got no done expected done");
        end else begin
            vectors++;
            if (lat !== FRAME + 1) begin
                miscompares++;
                $display("FAIL latency: got %0d expected %0d", lat, FRAME + 1);
            end
            vectors++;
            if (rxData !== e.rx || voltage !== e.rx[9:0]) begin
                miscompares++;
                $display("FAIL single_rx: got %h/%h expected %h/%h", rxData, voltage, e.rx, e.rx[9:0]);
            end
            vectors++;
            if (mosi_cap !== e.tx || rise_cnt !== 16) begin
                miscompares++;
                $display("FAIL single_mosi: got %h/%0d rises expected %h/16 rises", mosi_cap, rise_cnt, e.tx);
            end
            vectors++;
            if ({sample_valid, busy} !== 2'b10) begin
                miscompares++;
                $display("FAIL strobe: got %b expected %b", {sample_valid, busy}, 2'b10);
            end
        end
        @(negedge clk);
        vectors++;
        if ({done, cs, busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL done_width: got %b expected %b", {done, cs, busy}, 3'b010);
        end
    endtask

    task automatic test_start_while_busy;
        int   ndone, cslow;
        exp_t e;
        @(negedge clk);
        adc_word = 16'h1234;
        txData   = 16'hA5A5;
        start    = 1'b1;
        sbq.push_back('{rx: 16'h1234, tx: 16'hA5A5});
        @(negedge clk);
        ndone = 0;
        cslow = cs ? 0 : 1;
        // Extra pulses land in SHIFT, HOLD and DONE respectively.
        for (int i = 0; i < 400; i++) begin
            start = (i == 40 || i == 133 || i == 136);
            @(negedge clk);
            if (!cs) cslow++;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    e = sbq.pop_front();
                    vectors++;
                    if (rxData !== e.rx || mosi_cap !== e.tx) begin
                        miscompares++;
                        $display("FAIL busy_rx: got %h/%h expected %h/%h", rxData, mosi_cap, e.rx, e.tx);
                    end
                end
            end
        end
        start = 1'b0;
        sbq.delete();
        vectors++;
        if (ndone !== 1 || cslow !== 33 * CDIV) begin
            miscompares++;
            $display("FAIL busy_ignore: got %0d done/%0d cs-low expected 1/%0d", ndone, cslow, 33 * CDIV);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit   got;
        int   cshi, acc, ndone;
        exp_t e;
        @(negedge clk);
        adc_word = 16'hFFFF;
        txData   = 16'h0F0F;
        start    = 1'b1;
        sbq.push_back('{rx: 16'hFFFF, tx: 16'h0F0F});
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
        while (cyc < acc + 21 * CDIV + 2) @(negedge clk);
        vectors++;
        if (rise_cnt !== 11 || sck !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_position: got %0d rises sck=%b expected 11 rises sck=1", rise_cnt, sck);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        vectors++;
        if ({cs, sck, busy, done} !== 4'b1000 || rxData !== 16'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got %b/%h expected %b/%h", {cs, sck, busy, done}, rxData, 4'b1000, 16'h0);
        end
        sbq.delete();
        ndone = 0;
        repeat (200) begin
            @(negedge clk);
            if (done) ndone++;
        end
        vectors++;
        if (ndone !== 0) begin
            miscompares++;
            $display("FAIL abort_done: got %0d expected 0", ndone);
        end
        adc_word = 16'h8001;
        txData   = 16'h1357;
        start    = 1'b1;
        sbq.push_back('{rx: 16'h8001, tx: 16'h1357});
        @(negedge clk);
        start = 1'b0;
        wait_done(400, got, cshi);
        e = sbq.pop_front();
        vectors++;
        if (!got || rxData !== e.rx || voltage !== e.rx[9:0] || mosi_cap !== e.tx) begin
            miscompares++;
            $display("FAIL after_reset: got done=%b %h/%h/%h expected done=1 %h/%h/%h",
                     got, rxData, voltage, mosi_cap, e.rx, e.rx[9:0], e.tx);
        end
    endtask

    task automatic test_back_to_back;
        bit   got;
        int   cshi, gap, d1, d2;
        exp_t e;
        @(negedge clk);
        adc_word = 16'h0155;
        txData   = 16'hFFFF;
        start    = 1'b1;
        sbq.push_back('{rx: 16'h0155, tx: 16'hFFFF});
        for (int i = 0; i < 5 && cs; i++) @(negedge clk);
        adc_word = 16'h03AA;
        txData   = 16'h0000;
        sbq.push_back('{rx: 16'h03AA, tx: 16'h0000});
        wait_done(400, got, cshi);
        d1 = cyc;
        e  = sbq.pop_front();
        vectors++;
        if (!got || rxData !== e.rx || mosi_cap !== e.tx) begin
            miscompares++;
            $display("FAIL b2b_first: got done=%b %h/%h expected done=1 %h/%h", got, rxData, mosi_cap, e.rx, e.tx);
        end
        gap = cshi;
        for (int i = 0; i < 20 && cs; i++) begin
            @(negedge clk);
            if (cs) gap++;
        end
        start = 1'b0;
        vectors++;
        if (gap < CDIV) begin
            miscompares++;
            $display("FAIL b2b_gap: got %0d expected >= %0d", gap, CDIV);
        end
        wait_done(400, got, cshi);
        d2 = cyc;
        e  = sbq.pop_front();
        vectors++;
        if (!got || d2 - d1 !== FRAME + 2) begin
            miscompares++;
            $display("FAIL b2b_period: got %0d expected %0d", d2 - d1, FRAME + 2);
        end
        vectors++;
        if (rxData !== e.rx || voltage !== e.rx[9:0] || mosi_cap !== e.tx || rise_cnt !== 16) begin
            miscompares++;
            $display("FAIL b2b_second: got %h/%h/%0d expected %h/%h/16", rxData, mosi_cap, rise_cnt, e.rx, e.tx);
        end
    endtask
`else
    task automatic test_auto_trigger;
        bit          got;
        int          cshi, prev, now;
        exp_t        e;
        logic [15:0] words [3];
        words[0] = 16'h0123;
        words[1] = 16'h0321;
        words[2] = 16'hC2F0;
        prev = -1;
        for (int k = 0; k < 3; k++) begin
            adc_word = words[k];
            txData   = ~words[k];
            sbq.push_back('{rx: words[k], tx: ~words[k]});
            wait_done(SPER + 100, got, cshi);
            now = cyc;
            e   = sbq.pop_front();
            vectors++;
            if (!got || rxData !== e.rx || voltage !== e.rx[9:0] || mosi_cap !== e.tx) begin
                miscompares++;
                $display("FAIL auto_rx%0d: got done=%b %h/%h expected done=1 %h/%h", k, got, rxData, mosi_cap, e.rx, e.tx);
            end
            if (prev >= 0) begin
                vectors++;
                if (now - prev !== SPER) begin
                    miscompares++;
                    $display("FAIL auto_period%0d: got %0d expected %0d", k, now - prev, SPER);
                end
            end
            prev = now;
        end
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL auto_overrun: got %b expected 0", overrun);
        end
    endtask

    task automatic test_overrun;
        repeat (100) @(negedge clk);
        vectors++;
        if (o_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b expected 1", o_overrun);
        end
        repeat (300) @(negedge clk);
        vectors++;
        if (o_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: got %b expected 1", o_overrun);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUTO_TRIGGER_EN
        test_auto_trigger();
        test_overrun();
`else
        test_single_frame();
        test_start_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
